// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, exception
// causes and the controller state enumeration.
package lsu_pkg;

   // Memory access width encodings in instr[14:12]
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // RISC-V mcause exception codes
   localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RSP,
      FIN,
      EXC,
      DRAIN
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for a single memory access.
// Ports:
//   store      - 1 for a store, 0 for a load
//   funct3     - access width / signedness
//   addr_lo    - byte offset within the word
//   wdata      - raw store data (rs2)
//   rdata      - raw read word from memory
//   be         - byte enables for the word access
//   wdata_lane - store data replicated across all lanes
//   misaligned - access crosses its natural alignment
//   illegal    - funct3 not a valid load/store encoding
//   ld_data    - load data shifted down and sign/zero-extended
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic        store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic        misaligned,
   output logic        illegal,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      shifted    = rdata >> {addr_lo, 3'b000};
      be         = 4'b0000;
      wdata_lane = wdata;
      misaligned = 1'b0;
      illegal    = 1'b0;
      ld_data    = shifted;
      case (funct3)
         F3_B: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
            ld_data    = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            be         = 4'b0011 << addr_lo;
            wdata_lane = {2{wdata[15:0]}};
            misaligned = addr_lo[0];
            ld_data    = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_W: begin
            be         = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         // Unsigned variants exist only for loads
         F3_BU: begin
            be      = 4'b0001 << addr_lo;
            illegal = store;
            ld_data = {24'h0, shifted[7:0]};
         end
         F3_HU: begin
            be         = 4'b0011 << addr_lo;
            illegal    = store;
            misaligned = addr_lo[0];
            ld_data    = {16'h0, shifted[15:0]};
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer between execute and one valid/ready data
// memory port. One operation in flight; illegal or misaligned ops trap without
// memory traffic, a missing response times out into an access fault and the
// late response is drained before the next op is accepted.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req_*                      - decoded op from execute (valid/ready)
//   mem_req_*, mem_addr/we/be/wdata - memory request channel
//   mem_rsp_*                  - memory response channel
//   done_*                     - one-cycle completion with optional rd write
//   exc_*                      - one-cycle exception (cause, tval)
//   busy                       - an op is in progress
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   input  logic        mem_rsp_err,
   output logic        done_valid,
   output logic        done_wr_valid,
   output logic [4:0]  done_rd,
   output logic [31:0] done_rdata,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_tval,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic              store_q, store_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              drain_q, drain_d;
   logic              err_q, err_d;
   logic [31:0]       ldata_q, ldata_d;
   logic [3:0]        cause_q, cause_d;

   // The aligner classifies the incoming op while idle and formats the
   // captured op afterwards, so one instance serves both.
   logic              al_store;
   logic [2:0]        al_funct3;
   logic [1:0]        al_addr_lo;
   logic [31:0]       al_wdata;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata_lane;
   logic              al_misaligned;
   logic              al_illegal;
   logic [31:0]       al_ld_data;

   assign al_store   = (state_q == IDLE) ? req_store      : store_q;
   assign al_funct3  = (state_q == IDLE) ? req_funct3     : funct3_q;
   assign al_addr_lo = (state_q == IDLE) ? req_addr[1:0]  : addr_q[1:0];
   assign al_wdata   = (state_q == IDLE) ? req_wdata      : wdata_q;

   lsu_lane_align u_lane_align (
      .store      (al_store),
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .wdata      (al_wdata),
      .rdata      (mem_rsp_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata_lane),
      .misaligned (al_misaligned),
      .illegal    (al_illegal),
      .ld_data    (al_ld_data)
   );

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d       = state_q;
      store_d       = store_q;
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rd_d          = rd_q;
      cnt_d         = cnt_q;
      drain_d       = drain_q;
      err_d         = err_q;
      ldata_d       = ldata_q;
      cause_d       = cause_q;
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = 32'h0;
      mem_we        = 1'b0;
      mem_be        = 4'h0;
      mem_wdata     = 32'h0;
      done_valid    = 1'b0;
      done_wr_valid = 1'b0;
      done_rd       = 5'h0;
      done_rdata    = 32'h0;
      exc_valid     = 1'b0;
      exc_cause     = 4'h0;
      exc_tval      = 32'h0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd_d     = req_rd;
               drain_d  = 1'b0;
               err_d    = 1'b0;
               ldata_d  = 32'h0;
               if (al_illegal) begin
                  cause_d = CAUSE_ILLEGAL;
                  state_d = EXC;
               end else if (al_misaligned) begin
                  cause_d = req_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                  state_d = EXC;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {addr_q[31:2], 2'b00};
            mem_we        = store_q;
            mem_be        = al_be;
            mem_wdata     = al_wdata_lane;
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = RSP;
            end
         end
         RSP: begin
            if (mem_rsp_valid) begin
               err_d   = mem_rsp_err;
               ldata_d = store_q ? 32'h0 : al_ld_data;
               state_d = FIN;
            end else if (cnt_q == CNT_LAST) begin
               cause_d = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
               drain_d = 1'b1;
               state_d = EXC;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FIN: begin
            if (err_q) begin
               exc_valid = 1'b1;
               exc_cause = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
               exc_tval  = addr_q;
            end else begin
               done_valid    = 1'b1;
               done_wr_valid = !store_q && (rd_q != 5'd0);
               done_rd       = rd_q;
               done_rdata    = ldata_q;
            end
            state_d = IDLE;
         end
         EXC: begin
            exc_valid = 1'b1;
            exc_cause = cause_q;
            exc_tval  = (cause_q == CAUSE_ILLEGAL) ? 32'h0 : addr_q;
            state_d   = drain_q ? DRAIN : IDLE;
         end
         DRAIN: begin
            // The timed-out response may still arrive; swallow it first
            if (mem_rsp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         funct3_q <= 3'h0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rd_q     <= 5'h0;
         cnt_q    <= '0;
         drain_q  <= 1'b0;
         err_q    <= 1'b0;
         ldata_q  <= 32'h0;
         cause_q  <= 4'h0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         drain_q  <= drain_d;
         err_q    <= err_d;
         ldata_q  <= ldata_d;
         cause_q  <= cause_d;
      end
   end

endmodule
